irq_ctrl: RTL and testbench

- Parametrised memory-mapped interrupt controller for the AVR core; successor to the fixed two-source timer/keyboard interrupt logic in the top-level port controller.
- Latches up to NIRQ single-cycle event pulses (vsync, PS/2 done, SPI done, ...) into a pending register; the mask gates dispatch only.
- Dispatches one vector at a time to the core through the toggle-style intr/vect interface; holds further dispatch until software writes EOI.

---
 rtl/irq_ctrl_if.sv | 11 +
 rtl/irq_ctrl.sv | 134 +++++++++++++
 tb/tb_irq_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// CPU data-bus view of the interrupt controller register block.
interface irq_ctrl_if;
    logic [15:0] address;
    logic [7:0]  data_o;
    logic        we;
    logic [7:0]  rdata;
    logic        hit;

    modport master (output address, data_o, we, input rdata, hit);
    modport slave  (input address, data_o, we, output rdata, hit);
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches event pulses into PEND and dispatches one vector per EOI.
// Events reach intr two edges after the pulse. No dispatch until EOI. IRQ_CTRL_RR_EN selects round-robin priority.
module irq_ctrl #(
    parameter int          NIRQ   = 7,
    parameter int          VECT_W = 3,
    parameter logic [15:0] BASE   = 16'h0030
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NIRQ-1:0]   irq_in,
    irq_ctrl_if.slave         bus,
    output logic              intr,
    output logic [VECT_W-1:0] vect
);
    localparam int IDX_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] SERVICE = 1'b1;

    logic [0:0]      state;
    logic [NIRQ-1:0] pend;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] req;
    logic [NIRQ-1:0] pend_nxt;
    logic [IDX_W-1:0] grant;
    logic            found;
    logic [15:0]     offset;
    logic            sel;
    logic            wr_mask;
    logic            wr_pend;
    logic            wr_eoi;
    logic            dispatch;
    logic [7:0]      rd;
    logic            unused_data;

    // Subtracting BASE lets an unaligned base decode with a simple range test.
    assign offset      = bus.address - BASE;
    assign sel         = (offset[15:2] == 14'd0);
    assign wr_mask     = bus.we && sel && (offset[1:0] == 2'd0);
    assign wr_pend     = bus.we && sel && (offset[1:0] == 2'd1);
    assign wr_eoi      = bus.we && sel && (offset[1:0] == 2'd2);
    assign req         = pend & mask;
    assign dispatch    = (state == IDLE) && found;
    assign unused_data = ^bus.data_o;

`ifdef IRQ_CTRL_RR_EN
    logic [IDX_W-1:0] last;

    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int j = 0; j < NIRQ; j++) begin
            if (!found && req[(int'(last) + 1 + j) % NIRQ]) begin
                found = 1'b1;
                grant = IDX_W'((int'(last) + 1 + j) % NIRQ);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            last <= IDX_W'(NIRQ - 1);
        else if (dispatch)
            last <= grant;
    end
`else
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                grant = IDX_W'(i);
            end
        end
    end
`endif

    // New events are OR-ed in last so they win over both W1C and the dispatch clear.
    always_comb begin
        pend_nxt = pend;
        if (wr_pend)
            pend_nxt = pend_nxt & ~bus.data_o[NIRQ-1:0];
        if (dispatch)
            pend_nxt[grant] = 1'b0;
        pend_nxt = pend_nxt | irq_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pend  <= '0;
            mask  <= '0;
            intr  <= 1'b0;
            vect  <= '0;
        end else begin
            pend <= pend_nxt;
            if (wr_mask)
                mask <= bus.data_o[NIRQ-1:0];
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        vect  <= VECT_W'(grant) + VECT_W'(1);
                        intr  <= ~intr;
                        state <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (wr_eoi)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (offset[1:0])
            2'd0: rd[NIRQ-1:0]   = mask;
            2'd1: rd[NIRQ-1:0]   = pend;
            2'd2: rd[0]          = (state == SERVICE);
            2'd3: begin
                rd[VECT_W-1:0] = vect;
`ifdef IRQ_CTRL_RR_EN
                rd[7:4] = 4'(last);
`endif
            end
            default: rd = '0;
        endcase
    end

    assign bus.rdata = rd;
    assign bus.hit   = sel;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: register access, dispatch timing, priority, W1C races and reset.
module tb_irq_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] irq_in = '0;
    logic       intr;
    logic [2:0] vect;
    int         n_chk = 0;
    int         n_fail = 0;

    irq_ctrl_if bus();

    irq_ctrl #(.NIRQ(7), .VECT_W(3), .BASE(16'h0030)) dut (
        .clock (clock),
        .reset (reset),
        .irq_in(irq_in),
        .bus   (bus),
        .intr  (intr),
        .vect  (vect)
    );

    always #5 clock = ~clock;

`ifdef IRQ_CTRL_RR_EN
    localparam logic [2:0] V_FIRST  = 3'd4;
    localparam logic [2:0] V_SECOND = 3'd2;
    localparam logic [7:0] P_LEFT   = 8'h02;
`else
    localparam logic [2:0] V_FIRST  = 3'd2;
    localparam logic [2:0] V_SECOND = 3'd4;
    localparam logic [7:0] P_LEFT   = 8'h08;
`endif

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] r, input logic [7:0] d);
        bus.address = 16'h0030 + 16'(r);
        bus.data_o  = d;
        bus.we      = 1'b1;
        tick();
        bus.we      = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] r, input logic [7:0] exp);
        bus.address = 16'h0030 + 16'(r);
        #1;
        check(tag, 16'(bus.rdata), 16'(exp));
    endtask

    task automatic pulse(input logic [6:0] m);
        irq_in = m;
        tick();
        irq_in = '0;
    endtask

    initial begin
        bus.address = '0;
        bus.data_o  = '0;
        bus.we      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_intr", 16'(intr), 16'd0);
        check("rst_vect", 16'(vect), 16'd0);
        rd("rst_pend", 2'd1, 8'h00);
        rd("rst_mask", 2'd0, 8'h00);
        rd("rst_eoi", 2'd2, 8'h00);
        tick();
        bus.address = 16'h0034;
        #1 check("hit_above", 16'(bus.hit), 16'd0);
        bus.address = 16'h0033;
        #1 check("hit_top", 16'(bus.hit), 16'd1);
        tick();
        wr(2'd0, 8'h7F);
        rd("mask_rb", 2'd0, 8'h7F);
        wr(2'd0, 8'hFF);
        rd("mask_hibit", 2'd0, 8'h7F);

        // single source, merge while in service, EOI re-dispatch
        wr(2'd0, 8'h01);
        pulse(7'h01);
        check("t2_cycN", 16'(intr), 16'd0);
        tick();
        check("t2_intr", 16'(intr), 16'd1);
        check("t2_vect", 16'(vect), 16'd1);
        rd("t2_pend", 2'd1, 8'h00);
        rd("t2_insvc", 2'd2, 8'h01);
        tick();
        pulse(7'h01);
        tick();
        check("t2_hold", 16'(intr), 16'd1);
        rd("t2_pend2", 2'd1, 8'h01);
        wr(2'd2, 8'h00);
        check("t2_eoi_edge", 16'(intr), 16'd1);
        tick();
        check("t2_redisp", 16'(intr), 16'd0);
        check("t2_vect2", 16'(vect), 16'd1);
        rd("t2_pend3", 2'd1, 8'h00);
        wr(2'd2, 8'h00);
        rd("t2_idle", 2'd2, 8'h00);
        tick();

        // masked pending, dispatched on mask enable
        wr(2'd0, 8'h00);
        pulse(7'h04);
        tick();
        check("t3_masked", 16'(intr), 16'd0);
        rd("t3_pend", 2'd1, 8'h04);
        wr(2'd0, 8'h04);
        check("t3_mask_edge", 16'(intr), 16'd0);
        tick();
        check("t3_intr", 16'(intr), 16'd1);
        check("t3_vect", 16'(vect), 16'd3);
        wr(2'd2, 8'h00);
        tick();

        // simultaneous sources, priority order
        wr(2'd0, 8'h0A);
        pulse(7'h0A);
        check("t4_cycN", 16'(intr), 16'd1);
        tick();
        check("t4_intr1", 16'(intr), 16'd0);
        check("t4_vect1", 16'(vect), 16'(V_FIRST));
        rd("t4_pend", 2'd1, P_LEFT);
        wr(2'd2, 8'h00);
        tick();
        check("t4_intr2", 16'(intr), 16'd1);
        check("t4_vect2", 16'(vect), 16'(V_SECOND));
        wr(2'd2, 8'h00);
        tick();

        // set beats W1C clear, plain W1C, EOI ignored in IDLE
        wr(2'd0, 8'h00);
        irq_in      = 7'h02;
        bus.address = 16'h0031;
        bus.data_o  = 8'h02;
        bus.we      = 1'b1;
        tick();
        bus.we = 1'b0;
        irq_in = '0;
        rd("t5_setwins", 2'd1, 8'h02);
        wr(2'd1, 8'h02);
        rd("t5_w1c", 2'd1, 8'h00);
        wr(2'd2, 8'h00);
        rd("t5_eoi_idle", 2'd2, 8'h00);
        tick();
        check("t5_intr", 16'(intr), 16'd1);

        // reset while in service, then normal dispatch
        wr(2'd0, 8'h01);
        pulse(7'h01);
        tick();
        check("t6_intr", 16'(intr), 16'd0);
        check("t6_vect", 16'(vect), 16'd1);
        pulse(7'h01);
        rd("t6_pend", 2'd1, 8'h01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_intr", 16'(intr), 16'd0);
        check("t6_rst_vect", 16'(vect), 16'd0);
        rd("t6_rst_pend", 2'd1, 8'h00);
        rd("t6_rst_mask", 2'd0, 8'h00);
        tick();
        rd("t6_rst_eoi", 2'd2, 8'h00);
        wr(2'd0, 8'h01);
        pulse(7'h01);
        tick();
        check("t6_post_intr", 16'(intr), 16'd1);
        check("t6_post_vect", 16'(vect), 16'd1);
        rd("t6_vecreg", 2'd3, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
